serial_sub_ctrl: RTL and testbench

Bit-serial subtraction controller built around a single 1-bit full-subtractor cell (diff = a^b^bin, bout = ~a&b | ~a&bin | b&bin). It latches two WIDTH-bit operands on a start handshake and processes one bit per clock, LSB first, with a registered borrow. It returns the WIDTH-bit difference and final borrow with a one-cycle done pulse. It is the sequenced, area-minimal alternative to a WIDTH-wide ripple subtractor in the arithmetic section of the codebase.

---
 rtl/serial_sub_ctrl.sv | 113 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a-b: one full-subtractor cell, LSB first, WIDTH+2 cycles per operation.
// Optional feature macro SERIAL_SUB_SAT_EN: clamp diff to 0 when the final borrow is set.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_bor;
   logic             r_bout;
   logic             w_d;
   logic             w_bo;
   logic             w_last;
   logic [WIDTH-1:0] w_sh_nxt;
   logic [WIDTH-1:0] w_diff_ld;

   assign w_d      = r_a[0] ^ r_b[0] ^ r_bor;
   assign w_bo     = (~r_a[0] & r_b[0]) | (~r_a[0] & r_bor) | (r_b[0] & r_bor);
   assign w_last   = (r_cnt == CW'(WIDTH - 1));
   assign w_sh_nxt = {w_d, r_sh[WIDTH-1:1]};

`ifdef SERIAL_SUB_SAT_EN
   assign w_diff_ld = w_bo ? '0 : w_sh_nxt;
`else
   assign w_diff_ld = w_sh_nxt;
`endif

   assign diff       = r_diff;
   assign borrow_out = r_bout;

   always_comb begin
      w_state_nxt = r_state;
      ready       = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Result register loads on the final RUN edge, which is the edge that raises done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_sh   <= '0;
         r_cnt  <= '0;
         r_bor  <= 1'b0;
         r_diff <= '0;
         r_bout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_sh  <= '0;
                  r_cnt <= '0;
                  r_bor <= 1'b0;
               end
            end
            S_RUN: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_sh  <= w_sh_nxt;
               r_bor <= w_bo;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_diff <= w_diff_ld;
                  r_bout <= w_bo;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: WIDTH=8 and WIDTH=2 instances against a transaction-timeline model.
module tb_serial_sub_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       s8, s2;
   logic [7:0] a8, b8;
   logic [1:0] a2, b2;
   logic       rdy8, bsy8, dn8, bo8;
   logic [7:0] d8;
   logic       rdy2, bsy2, dn2, bo2;
   logic [1:0] d2;

   int vec  = 0;
   int miss = 0;

   serial_sub_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
      .ready(rdy8), .busy(bsy8), .done(dn8), .diff(d8), .borrow_out(bo8)
   );

   serial_sub_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2),
      .ready(rdy2), .busy(bsy2), .done(dn2), .diff(d2), .borrow_out(bo2)
   );

   // Observed outputs packed as {ready, busy, done, borrow_out, diff[7:0]}
   function automatic logic [11:0] obs(input int i);
      if (i == 0) return {rdy8, bsy8, dn8, bo8, d8};
      return {rdy2, bsy2, dn2, bo2, 6'b0, d2};
   endfunction

   function automatic int wid(input int i);
      return (i == 0) ? 8 : 2;
   endfunction

   function automatic logic [7:0] ref_diff(input int w, input int x, input int y);
      int m;
      m = (1 << w) - 1;
`ifdef SERIAL_SUB_SAT_EN
      if (x < y) return 8'h00;
`endif
      return 8'((x - y) & m);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: t = cycles since the accepting edge (-1 when idle).
   int         t[2]  = '{-1, -1};
   int         oa[2] = '{0, 0};
   int         ob[2] = '{0, 0};
   logic [7:0] ed[2] = '{8'h00, 8'h00};
   logic       eb[2] = '{1'b0, 1'b0};

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            t[i]  = -1;
            ed[i] = 8'h00;
            eb[i] = 1'b0;
         end else if (t[i] < 0) begin
            if ((i == 0) ? s8 : s2) begin
               t[i]  = 0;
               oa[i] = (i == 0) ? int'(a8) : int'(a2);
               ob[i] = (i == 0) ? int'(b8) : int'(b2);
            end
         end else begin
            t[i]++;
            if (t[i] == wid(i)) begin
               ed[i] = ref_diff(wid(i), oa[i], ob[i]);
               eb[i] = (oa[i] < ob[i]);
            end else if (t[i] == wid(i) + 1) begin
               t[i] = -1;
            end
         end
      end
   end

   function automatic logic [11:0] exp_obs(input int i);
      return {t[i] < 0, (t[i] >= 0) && (t[i] < wid(i)), t[i] == wid(i), eb[i], ed[i]};
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++)
         chk($sformatf("model_inst%0d", i), 32'(obs(i)), 32'(exp_obs(i)));
   end

   // One directed operation; called at posedge+2.
   task automatic run(input int i, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] exp_d, input logic exp_b);
      int   k, nb;
      logic got;
      k = 0;
      while (!obs(i)[11] && k < 100) begin
         @(posedge clk); #2;
         k++;
      end
      chk("ready_wait", 32'(obs(i)[11]), 32'd1);
      if (i == 0) begin s8 = 1'b1; a8 = x; b8 = y; end
      else begin s2 = 1'b1; a2 = x[1:0]; b2 = y[1:0]; end
      @(posedge clk); #2;
      s8 = 1'b0; s2 = 1'b0;
      k = 0; nb = 0; got = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (obs(i)[9]) begin got = 1'b1; break; end
         if (obs(i)[10]) nb++;
         k++;
      end
      chk("done_seen", 32'(got), 32'd1);
      chk("done_latency", 32'(k), 32'(wid(i)));
      chk("busy_cycles", 32'(nb), 32'(wid(i)));
      chk("diff", 32'(obs(i)[7:0]), 32'(exp_d));
      chk("borrow_out", 32'(obs(i)[8]), 32'(exp_b));
      @(negedge clk);
      chk("ready_after_done", 32'(obs(i)[11:9]), 32'b100);
      @(posedge clk); #2;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         nd, pb;
      logic [7:0] fd;
      logic       fb;
      int         acc[$];

      rst_n = 1'b0;
      s8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      s2 = 1'b0; a2 = 2'b00; b2 = 2'b00;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_inst8", 32'(obs(0)), 32'h800);
      chk("reset_inst2", 32'(obs(1)), 32'h800);
      rst_n = 1'b1;
      @(posedge clk); #2;
      chk("post_reset_inst8", 32'(obs(0)), 32'h800);

      run(0, 8'h5A, 8'h23, 8'h37, 1'b0);
`ifdef SERIAL_SUB_SAT_EN
      run(0, 8'h10, 8'h20, 8'h00, 1'b1);
`else
      run(0, 8'h10, 8'h20, 8'hF0, 1'b1);
`endif
      run(0, 8'hFF, 8'hFF, 8'h00, 1'b0);
`ifdef SERIAL_SUB_SAT_EN
      run(0, 8'h00, 8'h01, 8'h00, 1'b1);
`else
      run(0, 8'h00, 8'h01, 8'hFF, 1'b1);
`endif

      // Start held high; operands altered mid-RUN must not disturb the first result.
      nd = 0; pb = 0;
      s8 = 1'b1; a8 = 8'h09; b8 = 8'h04;
      @(posedge clk); #2;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (dn8) begin
            nd++;
            if (nd == 1) begin fd = d8; fb = bo8; end
         end
         if (bsy8 && pb == 0) acc.push_back(n);
         pb = int'(bsy8);
         @(posedge clk); #2;
         if (n == 2) begin a8 = 8'h01; b8 = 8'h02; end
         if (n == 18) s8 = 1'b0;
      end
      chk("stream_first_diff", 32'(fd), 32'h05);
      chk("stream_first_borrow", 32'(fb), 32'd0);
      chk("stream_done_pulses", 32'(nd), 32'd2);
      chk("stream_accepts", 32'(acc.size()), 32'd2);
      if (acc.size() == 2) chk("stream_accept_gap", 32'(acc[1] - acc[0]), 32'd10);

      // Reset during the 4th RUN cycle of 0x80-0x01.
      s8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
      @(posedge clk); #2;
      s8 = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("mid_run_reset", 32'(obs(0)), 32'h800);
      @(posedge clk); #2;
      rst_n = 1'b1;
      run(0, 8'h80, 8'h01, 8'h7F, 1'b0);

      for (int x = 0; x < 4; x++)
         for (int y = 0; y < 4; y++)
            run(1, 8'(x), 8'(y), ref_diff(2, x, y), x < y);

      // Random traffic on both instances; the per-cycle compare does the checking.
      for (int n = 0; n < 300; n++) begin
         s8 = ($urandom_range(0, 2) == 0);
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         s2 = ($urandom_range(0, 1) == 0);
         a2 = 2'($urandom);
         b2 = 2'($urandom);
         @(posedge clk); #2;
      end
      s8 = 1'b0; s2 = 1'b0;
      repeat (12) @(posedge clk);
      #2;
      chk("drain_idle_inst8", 32'(obs(0)[11:9]), 32'b100);
      chk("drain_idle_inst2", 32'(obs(1)[11:9]), 32'b100);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
